// File: rtl/bcd_codec_pkg.sv
// Shared types and elaboration-time helpers for the BCD/binary codec.
// Pure definitions: no logic, no latency, no flow control.
package bcd_codec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      MODE_BCD2BIN = 1'b0,
      MODE_BIN2BCD = 1'b1
   } mode_t;

   localparam int MAX_DIGITS = 16;

   // Largest value representable in 'digits' BCD digits, i.e. 10^digits - 1.
   function automatic logic [63:0] pow10_minus1(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec, input int digits);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits && vec[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit double-dabble correction: +3 when >=5 (bin->bcd), -3 when >=8 (bcd->bin).
// Combinational, zero latency, no flow control.
module bcd_digit_adjust
   import bcd_codec_pkg::*;
(
   input  logic [3:0] nibble,
   input  mode_t      mode,
   output logic [3:0] nibble_adj
);

   always_comb begin
      nibble_adj = nibble;
      if (mode == MODE_BIN2BCD && nibble >= 4'd5)
         nibble_adj = nibble + 4'd3;
      else if (mode == MODE_BCD2BIN && nibble >= 4'd8)
         nibble_adj = nibble - 4'd3;
   end

endmodule

// File: rtl/bcd_binary_codec.sv
// Iterative bidirectional BCD/binary converter; BIN_W+1 cycles to done_o (1 on invalid input).
// Single outstanding request: start_i is accepted only while ready_o, otherwise ignored.
module bcd_binary_codec
   import bcd_codec_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int BIN_W  = 27
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                start_i,
   input  logic                mode_i,
   input  logic [4*DIGITS-1:0] bcd_i,
   input  logic [BIN_W-1:0]    bin_i,
   output logic                ready_o,
   output logic                done_o,
   output logic                err_o,
   output logic [BIN_W-1:0]    bin_o,
   output logic [4*DIGITS-1:0] bcd_o
);

   localparam int          BCD_W   = 4 * DIGITS;
   localparam int          CNT_W   = $clog2(BIN_W + 1);
   localparam logic [63:0] BIN_MAX = pow10_minus1(DIGITS);

   generate
      if ((64'd1 << BIN_W) <= BIN_MAX) begin : g_bad_width
         $error("BIN_W too narrow to hold the largest DIGITS-digit decimal value");
      end
   endgenerate

   state_t               state_q, state_d;
   mode_t                mode_q;
   logic [BCD_W-1:0]     bcd_q, bcd_res_q;
   logic [BIN_W-1:0]     bin_q, bin_res_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 err_q;

   logic                 req_valid;
   logic                 last_step;
   logic [BCD_W+BIN_W-1:0] shr;
   logic [BCD_W-1:0]     adj_in, adj_out, step_bcd;
   logic [BIN_W-1:0]     step_bin;

   assign req_valid = (mode_i == MODE_BIN2BCD) ? (64'(bin_i) <= BIN_MAX)
                                               : bcd_valid(64'(bcd_i), DIGITS);
   assign last_step = (cnt_q == CNT_W'(1));

   // BCD->binary adjusts after the shift, binary->BCD adjusts before it.
   assign shr    = {bcd_q, bin_q} >> 1;
   assign adj_in = (mode_q == MODE_BCD2BIN) ? shr[BCD_W+BIN_W-1 -: BCD_W] : bcd_q;

   generate
      for (genvar d = 0; d < DIGITS; d++) begin : g_digit
         bcd_digit_adjust u_adj (
            .nibble     (adj_in[4*d +: 4]),
            .mode       (mode_q),
            .nibble_adj (adj_out[4*d +: 4])
         );
      end
   endgenerate

   always_comb begin
      step_bcd = adj_out;
      step_bin = shr[BIN_W-1:0];
      if (mode_q == MODE_BIN2BCD) {step_bcd, step_bin} = {adj_out, bin_q} << 1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = req_valid ? RUN : DONE;
         RUN:     if (last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mode_q    <= MODE_BCD2BIN;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         bcd_res_q <= '0;
         bin_res_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               mode_q <= mode_t'(mode_i);
               err_q  <= !req_valid;
               cnt_q  <= CNT_W'(BIN_W);
               if (mode_i == MODE_BIN2BCD) begin
                  bcd_q <= '0;
                  bin_q <= bin_i;
               end else begin
                  bcd_q <= bcd_i;
                  bin_q <= '0;
               end
               if (!req_valid) begin
                  if (mode_i == MODE_BIN2BCD) bcd_res_q <= '0;
                  else                        bin_res_q <= '0;
               end
            end
            RUN: begin
               bcd_q <= step_bcd;
               bin_q <= step_bin;
               cnt_q <= cnt_q - CNT_W'(1);
               if (last_step) begin
                  if (mode_q == MODE_BCD2BIN) bin_res_q <= step_bin;
                  else                        bcd_res_q <= step_bcd;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o = (state_q == IDLE);
   assign done_o  = (state_q == DONE);
   assign err_o   = err_q;
   assign bin_o   = bin_res_q;
   assign bcd_o   = bcd_res_q;

endmodule

// File: tb/tb_bcd_binary_codec.sv
// Bench for bcd_binary_codec: arithmetic reference model checked every cycle on a
// 4-digit instance, plus directed literal checks on 4-digit and default instances.
module tb_bcd_binary_codec;

   localparam int D = 4;
   localparam int W = 14;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b1;
   logic        start_i = 1'b0, mode_i = 1'b0;
   logic [15:0] bcd_i = '0;
   logic [13:0] bin_i = '0;
   logic        ready_o, done_o, err_o;
   logic [13:0] bin_o;
   logic [15:0] bcd_o;

   logic        l_start = 1'b0, l_mode = 1'b0;
   logic [31:0] l_bcd = '0;
   logic [26:0] l_bin = '0;
   logic        l_ready, l_done, l_err;
   logic [26:0] l_bin_o;
   logic [31:0] l_bcd_o;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   bcd_binary_codec #(.DIGITS(D), .BIN_W(W)) dut (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .mode_i(mode_i),
      .bcd_i(bcd_i), .bin_i(bin_i), .ready_o(ready_o), .done_o(done_o),
      .err_o(err_o), .bin_o(bin_o), .bcd_o(bcd_o)
   );

   bcd_binary_codec dut_l (
      .clk_i(clk), .reset_ni(reset_ni), .start_i(l_start), .mode_i(l_mode),
      .bcd_i(l_bcd), .bin_i(l_bin), .ready_o(l_ready), .done_o(l_done),
      .err_o(l_err), .bin_o(l_bin_o), .bcd_o(l_bcd_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (decimal arithmetic) ----------------
   function automatic bit bcd_ok(input logic [15:0] v);
      for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [13:0] from_bcd(input logic [15:0] v);
      int s = 0;
      for (int i = D - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
      return 14'(s);
   endfunction

   function automatic logic [15:0] to_bcd(input logic [13:0] b);
      int x = int'(b);
      logic [15:0] r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   int          m_rem = 0;
   bit          m_done = 1'b0;
   bit          e_err = 1'b0;
   logic [13:0] e_bin = '0, p_bin = '0;
   logic [15:0] e_bcd = '0, p_bcd = '0;
   bit          p_mode = 1'b0;

   always @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         m_rem <= 0; m_done <= 1'b0; e_err <= 1'b0; e_bin <= '0; e_bcd <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_done <= 1'b1;
            if (p_mode) e_bcd <= p_bcd;
            else        e_bin <= p_bin;
         end
      end else if (start_i) begin
         p_mode <= mode_i;
         if (mode_i) begin
            if (int'(bin_i) > 9999) begin
               e_err <= 1'b1; e_bcd <= '0; m_done <= 1'b1;
            end else begin
               e_err <= 1'b0; p_bcd <= to_bcd(bin_i); m_rem <= W;
            end
         end else begin
            if (!bcd_ok(bcd_i)) begin
               e_err <= 1'b1; e_bin <= '0; m_done <= 1'b1;
            end else begin
               e_err <= 1'b0; p_bin <= from_bcd(bcd_i); m_rem <= W;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ready_o", 64'(ready_o), 64'(m_rem == 0 && !m_done));
         check("done_o",  64'(done_o),  64'(m_done));
         check("err_o",   64'(err_o),   64'(e_err));
         check("bin_o",   64'(bin_o),   64'(e_bin));
         check("bcd_o",   64'(bcd_o),   64'(e_bcd));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_ready();
      int g = 0;
      @(negedge clk);
      while (!ready_o && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait", 64'(g < 100), 64'd1);
   endtask

   // Returns at the negedge of the done cycle; lat counts edges from accept.
   task automatic req_s(input bit md, input logic [15:0] bcd, input logic [13:0] bin,
                        output int lat);
      wait_ready();
      mode_i = md; bcd_i = bcd; bin_i = bin; start_i = 1'b1;
      @(posedge clk);
      #2 start_i = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done_o && lat < 100);
   endtask

   task automatic req_l(input bit md, input logic [31:0] bcd, input logic [26:0] bin,
                        output int lat);
      int g = 0;
      @(negedge clk);
      while (!l_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("l_ready_wait", 64'(g < 100), 64'd1);
      l_mode = md; l_bcd = bcd; l_bin = bin; l_start = 1'b1;
      @(posedge clk);
      #2 l_start = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!l_done && lat < 200);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      #1 reset_ni = 1'b0;
      #2 cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_bin",   64'(bin_o),   64'd0);
      reset_ni = 1'b1;

      req_s(1'b0, 16'h0042, 14'd0, lat);
      check("b2n_42_lat", 64'(lat), 64'd15);
      check("b2n_42_val", 64'(bin_o), 64'd42);
      check("b2n_42_err", 64'(err_o), 64'd0);

      req_s(1'b1, 16'h0, 14'd9999, lat);
      check("n2b_9999_val", 64'(bcd_o), 64'h9999);
      check("n2b_9999_lat", 64'(lat), 64'd15);
      req_s(1'b1, 16'h0, 14'd0, lat);
      check("n2b_0_val", 64'(bcd_o), 64'h0);
      check("n2b_0_binheld", 64'(bin_o), 64'd42);

      req_s(1'b1, 16'h0, 14'd10000, lat);
      check("n2b_ovf_lat", 64'(lat), 64'd1);
      check("n2b_ovf_err", 64'(err_o), 64'd1);
      check("n2b_ovf_val", 64'(bcd_o), 64'h0);
      req_s(1'b0, 16'h00A1, 14'd0, lat);
      check("b2n_bad_lat", 64'(lat), 64'd1);
      check("b2n_bad_err", 64'(err_o), 64'd1);
      check("b2n_bad_val", 64'(bin_o), 64'd0);

      // Abort a conversion with reset after leaving nonzero held results behind.
      req_s(1'b1, 16'h0, 14'd1234, lat);
      check("n2b_1234_val", 64'(bcd_o), 64'h1234);
      wait_ready();
      mode_i = 1'b0; bcd_i = 16'h5678; start_i = 1'b1;
      @(posedge clk);
      #2 start_i = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_ni = 1'b0;
      #1;
      check("abort_ready", 64'(ready_o), 64'd1);
      check("abort_done",  64'(done_o),  64'd0);
      check("abort_bcd",   64'(bcd_o),   64'd0);
      @(negedge clk);
      reset_ni = 1'b1;
      req_s(1'b0, 16'h1234, 14'd0, lat);
      check("after_abort_val", 64'(bin_o), 64'd1234);

      // start_i held high; operand changes mid-run must not leak into the result.
      wait_ready();
      mode_i = 1'b0; bcd_i = 16'h0042; start_i = 1'b1;
      @(posedge clk);
      #2 bcd_i = 16'h0777;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done_o && lat < 100);
      check("hold_lat", 64'(lat), 64'd15);
      check("hold_val", 64'(bin_o), 64'd42);
      @(negedge clk);
      check("hold_idle_ready", 64'(ready_o), 64'd1);
      @(posedge clk);
      #2 check("hold_reaccept", 64'(ready_o), 64'd0);
      start_i = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done_o && lat < 100);
      check("hold2_val", 64'(bin_o), 64'd777);

      // Random traffic, including mid-run operand churn and out-of-range values.
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(negedge clk);
         start_i = ($urandom_range(0, 3) != 0);
         mode_i  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) bcd_i = 16'($urandom);
         else for (int i = 0; i < D; i++) bcd_i[4*i +: 4] = 4'($urandom_range(0, 9));
         r = $urandom_range(0, 7);
         if (r == 0)      bin_i = 14'd9999;
         else if (r == 1) bin_i = 14'd10000;
         else if (r == 2) bin_i = 14'($urandom);
         else             bin_i = 14'($urandom_range(0, 9999));
      end
      @(negedge clk);
      start_i = 1'b0;
      repeat (40) @(negedge clk);

      // Default-parameter instance.
      req_l(1'b1, 32'h0, 27'd99999999, lat);
      check("l_n2b_lat", 64'(lat), 64'd28);
      check("l_n2b_val", 64'(l_bcd_o), 64'h99999999);
      check("l_n2b_err", 64'(l_err), 64'd0);
      req_l(1'b0, 32'h99999999, 27'd0, lat);
      check("l_b2n_val", 64'(l_bin_o), 64'd99999999);
      check("l_b2n_lat", 64'(lat), 64'd28);
      req_l(1'b1, 32'h0, 27'd100000000, lat);
      check("l_ovf_err", 64'(l_err), 64'd1);
      check("l_ovf_lat", 64'(lat), 64'd1);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_binary_codec.md
Name: bcd_binary_codec

Overview:
Parametrised, bidirectional, iterative BCD/binary converter; successor to the single-direction BCD-to-binary converter. A per-request mode selects BCD->binary (reverse double-dabble: shift right, subtract 3) or binary->BCD (double-dabble: add 3, shift left). Adds input validation with an error flag, a start/ready/done handshake, and held results. Sits between the keypad/display front-end and the arithmetic datapath.

Parameters:
DIGITS, 8, number of BCD digits; BCD width = 4*DIGITS.
BIN_W, 27, binary width; must satisfy 2^BIN_W > 10^DIGITS-1, checked by elaboration assertion.

Ports:
clk_i  input  1  clock, rising edge
reset_ni  input  1  asynchronous active-low reset
start_i  input  1  request; accepted only when start_i && ready_o at a rising edge
mode_i  input  1  0 = BCD->binary, 1 = binary->BCD; sampled at accept
bcd_i  input  4*DIGITS  BCD operand; sampled at accept
bin_i  input  BIN_W  binary operand; sampled at accept
ready_o  output  1  high only in IDLE
done_o  output  1  one-cycle pulse, results valid
err_o  output  1  error for last request; held until next accept
bin_o  output  BIN_W  BCD->binary result; held
bcd_o  output  4*DIGITS  binary->BCD result; held

Behaviour:
- Reset (async assert, sync release): state IDLE; ready_o=1, done_o=0, err_o=0, bin_o=0, bcd_o=0; iteration counter and working registers cleared. Reset mid-conversion aborts it; no done_o is issued.
- States: IDLE, RUN, DONE.
- IDLE: ready_o=1. On accept edge E0, latch mode and operands and validate:
  - mode 0: if any nibble of bcd_i > 9, go to DONE with err=1.
  - mode 1: if bin_i > 10^DIGITS-1 (constant from package function), go to DONE with err=1.
  - Otherwise go to RUN with counter = BIN_W and err=0.
- RUN: ready_o=0. One shift/adjust step per edge, for exactly BIN_W edges (E1..E_BIN_W). The counter decrements each step; leave for DONE when the counter reaches 1 on a step.
  - Mode 0: concatenate {bcd, bin}, logical shift right by 1, then subtract 3 from every BCD digit that is >= 8.
  - Mode 1: add 3 to every BCD digit that is >= 5, then shift {bcd, bin} left by 1.
- DONE: exactly one cycle. done_o=1 and the output registers are updated on entry:
  - Valid mode 0: bin_o updated, bcd_o unchanged.
  - Valid mode 1: bcd_o updated, bin_o unchanged.
  - Error: result of the selected mode forced to 0, err_o=1.
  - The next edge returns to IDLE.
- Latency, valid request: done_o high in the cycle after edge E_BIN_W, i.e. BIN_W+1 edges after accept (last shift edge included). ready_o high again in the following cycle.
- Latency, invalid request: done_o high in the cycle immediately after E0.
- start_i while not in IDLE is ignored; there is no queueing. Inputs changing during RUN have no effect.
- Back-to-back: start_i held high re-accepts on the first IDLE edge, so the minimum period is BIN_W+2 cycles.
- err_o and results persist until the next accept. At accept, err_o is cleared only when the request is valid.
- All arithmetic is unsigned. Per-digit adjust stays within 4 bits by construction; no saturation is needed.

Decomposition:
- Package bcd_codec_pkg:
  - state_t enum (IDLE, RUN, DONE)
  - mode_t enum (MODE_BCD2BIN=0, MODE_BIN2BCD=1)
  - function pow10_minus1(digits) for the overflow bound
  - function bcd_valid(vector, digits)
- Sub-module bcd_digit_adjust: combinational, one per digit, generated DIGITS times. Inputs: nibble, mode. Output: nibble + 3 if mode 1 and >= 5; nibble - 3 if mode 0 and >= 8; else the nibble unchanged.

Test Plan:
(DIGITS=4, BIN_W=14 unless noted)
- mode 0, bcd_i=16'h0042 -> done_o 15 cycles after accept, bin_o=14'd42, err_o=0; ready_o low for 15 cycles.
- mode 1, bin_i=9999 -> bcd_o=16'h9999, err_o=0; then bin_i=0 -> bcd_o=16'h0000; bin_o keeps its previous value.
- mode 1, bin_i=10000 -> done_o the cycle after accept, err_o=1, bcd_o=0. Mode 0, bcd_i=16'h00A1 -> done_o next cycle, err_o=1, bin_o=0.
- Reset mid-RUN: reset_ni low 5 cycles after accept -> immediately ready_o=1, all outputs 0, no done_o; a following request of 16'h1234 -> bin_o=1234.
- start_i held high across a run with bcd_i changed mid-RUN -> result uses the latched operand; next accept occurs in the IDLE cycle after DONE; exactly one done_o per accept.
- Default params (DIGITS=8, BIN_W=27), mode 1, bin_i=99999999 -> bcd_o=32'h99999999 after 28 cycles; mode 0 round-trip returns 99999999.
